// File: rtl/shift_sequence_counter.sv
// Shift-sequence counter: emits a bounded train of shift enables for a serial
// datapath, with start/done handshake, hold, abort and auto-reload.
module shift_sequence_counter #(
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] length,
  input  logic                 auto_reload,
  input  logic                 hold,
  input  logic                 abort,
  output logic                 shift_en,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;
  logic [CNT_WIDTH-1:0] len_reg, len_next;
  logic                 done_reg, done_next;
  logic                 overflow_reg, overflow_next;
  logic                 load;
  logic                 shift_step;
  logic                 last_step;

  // A shift happens only in RUN when neither paused nor aborted this cycle.
  assign shift_step = (state_reg == ST_RUN) && !hold && !abort;
  // len_reg is never zero in RUN, so len_reg-1 cannot underflow here.
  assign last_step  = shift_step && (count_reg == (len_reg - CNT_ONE));

  // New sequence request: a start from IDLE/DONE, or a reload out of DONE.
  always_comb begin
    load = 1'b0;
    if (!abort) begin
      case (state_reg)
        ST_IDLE: load = start;
        ST_DONE: load = auto_reload || start;
        default: load = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    len_next      = len_reg;
    overflow_next = overflow_reg;
    if (abort) begin
      state_next    = ST_IDLE;
      count_next    = CNT_ZERO;
      overflow_next = 1'b0;
    end else if (load) begin
      len_next   = length;
      count_next = CNT_ZERO;
      // A zero-length sequence completes immediately with no shifts.
      if (length == CNT_ZERO) begin
        state_next    = ST_DONE;
        overflow_next = 1'b1;
      end else begin
        state_next    = ST_RUN;
        overflow_next = 1'b0;
      end
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (shift_step) begin
            count_next = count_reg + CNT_ONE;
            if (last_step) begin
              state_next    = ST_DONE;
              overflow_next = 1'b1;
            end
          end
        end
        ST_DONE: state_next = ST_IDLE;
        default: state_next = state_reg;
      endcase
    end
    done_next = (state_next == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      count_reg    <= CNT_ZERO;
      len_reg      <= CNT_ZERO;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      len_reg      <= len_next;
      done_reg     <= done_next;
      overflow_reg <= overflow_next;
    end
  end

  assign shift_en = shift_step;
  assign busy     = (state_reg == ST_RUN);
  assign count    = count_reg;
  assign done     = done_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_shift_sequence_counter.sv
// Scoreboard bench for shift_sequence_counter: the driver predicts each
// sequence's completion; an independent monitor checks every done pulse.
module tb_shift_sequence_counter;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst, start, auto_reload, hold, abort;
  logic [W-1:0] length;
  logic         shift_en, busy, done, overflow;
  logic [W-1:0] count;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int shift_cnt = 0;
  int last_n = 0;

  typedef struct {
    int n;
    int done_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   hold_pat[$];

  shift_sequence_counter #(.CNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .auto_reload(auto_reload), .hold(hold), .abort(abort),
    .shift_en(shift_en), .count(count), .busy(busy), .done(done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Monitor: counts shifts and checks each done pulse against the scoreboard.
  always @(negedge clk) begin
    if (shift_en === 1'b1) shift_cnt++;
    if (rst === 1'b1 || abort === 1'b1) shift_cnt = 0;
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending sequence at cycle %0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_cycle", cyc, mon_e.done_cyc);
        check("done_count", 32'(count), mon_e.n);
        check("done_overflow", 32'(overflow), 1);
        check("done_shifts", shift_cnt, mon_e.n);
        check("done_busy", 32'(busy), 0);
        $display("seq n=%0d done at cycle %0d shifts=%0d count=%0d", mon_e.n, cyc, shift_cnt, count);
      end
      shift_cnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [W-1:0] l, input logic ar,
                       input logic h, input logic ab);
    start = s; length = l; auto_reload = ar; hold = h; abort = ab;
  endtask

  // Hold pattern over the RUN window: n non-hold cycles, random holds between.
  task automatic make_pattern(input int n, input int pct);
    int zeros = 0;
    hold_pat.delete();
    while (zeros < n) begin
      if (int'($urandom_range(99)) < pct) hold_pat.push_back(1'b1);
      else begin
        hold_pat.push_back(1'b0);
        zeros++;
      end
    end
  endtask

  // Issue a sequence in the current cycle (IDLE start, DONE start or reload).
  task automatic do_seq(input int n, input bit reload);
    int t;
    exp_t e;
    if (reload) drive(1'($urandom_range(1)), W'(n), 1'b1, 1'($urandom_range(1)), 1'b0);
    else drive(1'b1, W'(n), 1'b0, 1'($urandom_range(1)), 1'b0);
    t = cyc;
    e.n = n;
    e.done_cyc = t + hold_pat.size() + 1;
    exp_q.push_back(e);
    last_n = n;
    @(negedge clk);
    check("busy_at_start", 32'(busy), 0);
    check("shift_en_at_start", 32'(shift_en), 0);
    foreach (hold_pat[i]) begin
      step();
      drive(1'($urandom_range(1)), W'($urandom), 1'($urandom_range(1)), hold_pat[i], 1'b0);
      @(negedge clk);
      check("busy_run", 32'(busy), 1);
      check("shift_en_run", 32'(shift_en), hold_pat[i] ? 0 : 1);
    end
  endtask

  task automatic fresh(input int n);
    step();
    do_seq(n, 1'b0);
  endtask

  task automatic chain(input int n);
    step();
    do_seq(n, 1'b0);
  endtask

  task automatic reload(input int n);
    step();
    do_seq(n, 1'b1);
  endtask

  // Leave DONE without restarting, then confirm the IDLE hold-over state.
  task automatic to_idle();
    step();
    drive(1'b0, W'($urandom), 1'b0, 1'($urandom_range(1)), 1'b0);
    step();
    drive(1'b0, W'($urandom), 1'b0, 1'($urandom_range(1)), 1'b0);
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    check("idle_overflow", 32'(overflow), 1);
    check("idle_count", 32'(count), last_n);
  endtask

  task automatic kill_test(input int n, input int k, input bit use_rst);
    step();
    drive(1'b1, W'(n), 1'b0, 1'b0, 1'b0);
    repeat (k) begin
      step();
      drive(1'b0, W'(n), 1'b0, 1'b0, 1'b0);
    end
    step();
    if (use_rst) begin
      drive(1'b0, W'(n), 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
    end else drive(1'b0, W'(n), 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("count_before_kill", 32'(count), k);
    if (!use_rst) check("shift_en_on_abort", 32'(shift_en), 0);
    step();
    rst = 1'b0;
    drive(1'b0, W'(n), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("kill_busy", 32'(busy), 0);
    check("kill_count", 32'(count), 0);
    check("kill_overflow", 32'(overflow), 0);
    check("kill_shift_en", 32'(shift_en), 0);
    repeat (3) step();
  endtask

  initial begin
    int mode, n, pct;
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_count", 32'(count), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_shift_en", 32'(shift_en), 0);
    check("reset_done", 32'(done), 0);
    check("reset_overflow", 32'(overflow), 0);

    make_pattern(16, 0);
    fresh(16);
    to_idle();

    hold_pat.delete();
    hold_pat.push_back(1'b0); hold_pat.push_back(1'b0);
    hold_pat.push_back(1'b1); hold_pat.push_back(1'b1);
    hold_pat.push_back(1'b0); hold_pat.push_back(1'b0);
    fresh(4);
    to_idle();

    kill_test(10, 5, 1'b0);
    kill_test(8, 3, 1'b1);

    make_pattern(3, 0);
    fresh(3);
    reload(3);
    reload(3);
    make_pattern(5, 0);
    reload(5);
    to_idle();

    hold_pat.delete();
    fresh(0);
    to_idle();
    make_pattern(31, 0);
    fresh(31);
    make_pattern(5, 20);
    chain(5);
    to_idle();

    step();
    drive(1'b1, W'(7), 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 0);
    check("rst_start_count", 32'(count), 0);
    check("rst_start_overflow", 32'(overflow), 0);

    make_pattern(2, 0);
    fresh(2);
    to_idle();
    step();
    drive(1'b1, W'(5), 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("start_abort_shift_en", 32'(shift_en), 0);
    step();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("start_abort_busy", 32'(busy), 0);
    check("start_abort_shift_en_next", 32'(shift_en), 0);
    check("start_abort_overflow", 32'(overflow), 0);
    check("start_abort_count", 32'(count), 0);

    make_pattern(6, 30);
    fresh(6);
    repeat (30) begin
      mode = int'($urandom_range(2));
      n    = int'($urandom_range(31));
      pct  = int'($urandom_range(40));
      make_pattern(n, pct);
      case (mode)
        0: begin
          to_idle();
          fresh(n);
        end
        1: chain(n);
        default: reload(n);
      endcase
    end
    to_idle();

    repeat (4) step();
    check("pending_expectations", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
